// File: rtl/memory_write_split_pkg.sv
// Shared types for the memory write splitter: FSM state encoding and a
// length-legality helper used by the protocol checker.
package mem_write_pkg;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_FIRST  = 2'd1;
  localparam logic [1:0] STATE_SECOND = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = STATE_IDLE,
    ST_FIRST  = STATE_FIRST,
    ST_SECOND = STATE_SECOND
  } state_t;

  function automatic logic len_legal(input int unsigned len, input int unsigned max_bytes);
    return (len != 32'd0) && (len <= max_bytes);
  endfunction

endpackage

// File: rtl/memory_write_split_if.sv
// Execute-side write port and TLB write port of the write splitter.
// master = execute unit + TLB (environment), slave = the splitter.
interface memory_write_split_if #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
);
  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int LEN_W  = $clog2(MAX_BYTES) + 1;

  logic              wr_reset;
  logic              write_do;
  logic              write_done;
  logic              write_page_fault;
  logic              write_ac_fault;
  logic [1:0]        write_cpl;
  logic [ADDR_W-1:0] write_address;
  logic [LEN_W-1:0]  write_length;
  logic              write_lock;
  logic              write_rmw;
  logic [DATA_W-1:0] write_data;
  logic              busy;

  logic              tlbwrite_do;
  logic              tlbwrite_done;
  logic              tlbwrite_page_fault;
  logic              tlbwrite_ac_fault;
  logic [1:0]        tlbwrite_cpl;
  logic [ADDR_W-1:0] tlbwrite_address;
  logic [LEN_W-1:0]  tlbwrite_length;
  logic [LEN_W-1:0]  tlbwrite_length_full;
  logic              tlbwrite_lock;
  logic              tlbwrite_rmw;
  logic [DATA_W-1:0] tlbwrite_data;

  modport master (
    output wr_reset, write_do, write_cpl, write_address, write_length,
           write_lock, write_rmw, write_data,
           tlbwrite_done, tlbwrite_page_fault, tlbwrite_ac_fault,
    input  write_done, write_page_fault, write_ac_fault, busy,
           tlbwrite_do, tlbwrite_cpl, tlbwrite_address, tlbwrite_length,
           tlbwrite_length_full, tlbwrite_lock, tlbwrite_rmw, tlbwrite_data
  );

  modport slave (
    input  wr_reset, write_do, write_cpl, write_address, write_length,
           write_lock, write_rmw, write_data,
           tlbwrite_done, tlbwrite_page_fault, tlbwrite_ac_fault,
    output write_done, write_page_fault, write_ac_fault, busy,
           tlbwrite_do, tlbwrite_cpl, tlbwrite_address, tlbwrite_length,
           tlbwrite_length_full, tlbwrite_lock, tlbwrite_rmw, tlbwrite_data
  );

endinterface

// File: rtl/mem_line_split.sv
// Splits one access at a line boundary into a first part and an optional
// second part starting at the next line. Purely combinational.
module mem_line_split #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int MAX_BYTES  = 4,
  parameter int DATA_W     = 8 * MAX_BYTES,
  parameter int LEN_W      = $clog2(MAX_BYTES) + 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic [LEN_W-1:0]  len1,
  output logic [LEN_W-1:0]  len2,
  output logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] data2
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int HI_W  = ADDR_W - OFF_W;

  logic [OFF_W-1:0] off_s;
  logic [OFF_W:0]   room_s;
  logic [OFF_W:0]   len_ext_s;
  logic [OFF_W:0]   len1_wide_s;
  logic [HI_W-1:0]  hi_s;

  // Bytes left in the line bound the first part; the line index wraps.
  always_comb begin
    off_s     = addr[OFF_W-1:0];
    room_s    = (OFF_W + 1)'(LINE_BYTES) - {1'b0, off_s};
    len_ext_s = (OFF_W + 1)'(len);
    if (len_ext_s > room_s) begin
      len1_wide_s = room_s;
    end else begin
      len1_wide_s = len_ext_s;
    end
    len1  = len1_wide_s[LEN_W-1:0];
    len2  = len - len1;
    hi_s  = addr[ADDR_W-1:OFF_W] + HI_W'(1);
    addr2 = {hi_s, {OFF_W{1'b0}}};
    data2 = data >> {len1, 3'b000};
  end

endmodule

// File: rtl/memory_write_split_chk.sv
// Protocol checker: a request presented to an idle splitter must carry a
// length of 1..MAX_BYTES.
module memory_write_split_chk
  import mem_write_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES) + 1
) (
  input logic             clk,
  input logic             rst_n,
  input logic             req_idle,
  input logic [LEN_W-1:0] len
);

  a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
    req_idle |-> len_legal(32'(len), 32'(MAX_BYTES)));

endmodule

// File: rtl/memory_write_split.sv
// Captures one execute-side write and issues it to the TLB as one part, or
// two parts when it crosses a line boundary; tracks sticky faults and flushes.
module memory_write_split #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int MAX_BYTES  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  memory_write_split_if.slave  bus
);
  import mem_write_pkg::*;

  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int LEN_W  = $clog2(MAX_BYTES) + 1;

  state_t            state_q, state_d;
  logic              do_q, do_d;
  logic [1:0]        cpl_q, cpl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  len_full_q, len_full_d;
  logic              lock_q, lock_d;
  logic              rmw_q, rmw_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [LEN_W-1:0]  len2_q, len2_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic              reset_waiting_q, reset_waiting_d;
  logic              page_sticky_q, page_sticky_d;
  logic              ac_sticky_q, ac_sticky_d;

  logic [LEN_W-1:0]  split_len1_s;
  logic [LEN_W-1:0]  split_len2_s;
  logic [ADDR_W-1:0] split_addr2_s;
  logic [DATA_W-1:0] split_data2_s;
  logic              page_fault_s;
  logic              ac_fault_s;
  logic              tlb_fault_s;
  logic              accept_s;
  logic              done_s;

  mem_line_split #(
    .ADDR_W     (ADDR_W),
    .LINE_BYTES (LINE_BYTES),
    .MAX_BYTES  (MAX_BYTES),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W)
  ) u_split (
    .addr  (bus.write_address),
    .len   (bus.write_length),
    .data  (bus.write_data),
    .len1  (split_len1_s),
    .len2  (split_len2_s),
    .addr2 (split_addr2_s),
    .data2 (split_data2_s)
  );

  memory_write_split_chk #(
    .MAX_BYTES (MAX_BYTES),
    .LEN_W     (LEN_W)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_idle (state_q == ST_IDLE && bus.write_do),
    .len      (bus.write_length)
  );

  // Fault and completion qualifiers; a fault always beats a same-cycle done.
  always_comb begin
    page_fault_s = bus.tlbwrite_page_fault | page_sticky_q;
    ac_fault_s   = bus.tlbwrite_ac_fault | ac_sticky_q;
    tlb_fault_s  = bus.tlbwrite_page_fault | bus.tlbwrite_ac_fault;
    accept_s     = (state_q == ST_IDLE) & bus.write_do & ~bus.wr_reset
                   & ~page_fault_s & ~ac_fault_s;
    if (state_q == ST_SECOND) begin
      done_s = bus.tlbwrite_done & ~tlb_fault_s;
    end else if (state_q == ST_FIRST) begin
      done_s = bus.tlbwrite_done & ~tlb_fault_s & (len2_q == {LEN_W{1'b0}});
    end else begin
      done_s = 1'b0;
    end
  end

  // Next-state logic for the FSM, the captured request and the part registers.
  always_comb begin
    state_d    = state_q;
    do_d       = do_q;
    cpl_d      = cpl_q;
    addr_d     = addr_q;
    len_d      = len_q;
    len_full_d = len_full_q;
    lock_d     = lock_q;
    rmw_d      = rmw_q;
    data_d     = data_q;
    addr2_d    = addr2_q;
    len2_d     = len2_q;
    data2_d    = data2_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_FIRST;
          do_d       = 1'b1;
          cpl_d      = bus.write_cpl;
          addr_d     = bus.write_address;
          len_d      = split_len1_s;
          len_full_d = bus.write_length;
          lock_d     = bus.write_lock;
          rmw_d      = bus.write_rmw;
          data_d     = bus.write_data;
          addr2_d    = split_addr2_s;
          len2_d     = split_len2_s;
          data2_d    = split_data2_s;
        end else begin
          do_d = 1'b0;
        end
      end
      ST_FIRST: begin
        if (tlb_fault_s) begin
          state_d = ST_IDLE;
          do_d    = 1'b0;
        end else if (bus.tlbwrite_done && len2_q != {LEN_W{1'b0}}) begin
          state_d = ST_SECOND;
          addr_d  = addr2_q;
          len_d   = len2_q;
          data_d  = data2_q;
        end else if (bus.tlbwrite_done) begin
          state_d = ST_IDLE;
          do_d    = 1'b0;
        end else begin
          state_d = ST_FIRST;
        end
      end
      ST_SECOND: begin
        if (tlb_fault_s || bus.tlbwrite_done) begin
          state_d = ST_IDLE;
          do_d    = 1'b0;
        end else begin
          state_d = ST_SECOND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        do_d    = 1'b0;
      end
    endcase
  end

  // A flush during a transfer lets the TLB finish but hides its outcome.
  always_comb begin
    if (state_q == ST_IDLE) begin
      reset_waiting_d = 1'b0;
    end else if (bus.wr_reset) begin
      reset_waiting_d = 1'b1;
    end else begin
      reset_waiting_d = reset_waiting_q;
    end
    if (bus.wr_reset) begin
      page_sticky_d = 1'b0;
      ac_sticky_d   = 1'b0;
    end else begin
      page_sticky_d = page_sticky_q | (bus.tlbwrite_page_fault & ~reset_waiting_q);
      ac_sticky_d   = ac_sticky_q | (bus.tlbwrite_ac_fault & ~reset_waiting_q);
    end
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      do_q            <= 1'b0;
      cpl_q           <= 2'd0;
      addr_q          <= {ADDR_W{1'b0}};
      len_q           <= {LEN_W{1'b0}};
      len_full_q      <= {LEN_W{1'b0}};
      lock_q          <= 1'b0;
      rmw_q           <= 1'b0;
      data_q          <= {DATA_W{1'b0}};
      addr2_q         <= {ADDR_W{1'b0}};
      len2_q          <= {LEN_W{1'b0}};
      data2_q         <= {DATA_W{1'b0}};
      reset_waiting_q <= 1'b0;
      page_sticky_q   <= 1'b0;
      ac_sticky_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      do_q            <= do_d;
      cpl_q           <= cpl_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      len_full_q      <= len_full_d;
      lock_q          <= lock_d;
      rmw_q           <= rmw_d;
      data_q          <= data_d;
      addr2_q         <= addr2_d;
      len2_q          <= len2_d;
      data2_q         <= data2_d;
      reset_waiting_q <= reset_waiting_d;
      page_sticky_q   <= page_sticky_d;
      ac_sticky_q     <= ac_sticky_d;
    end
  end

  assign bus.write_done           = done_s & ~reset_waiting_q;
  assign bus.write_page_fault     = page_fault_s;
  assign bus.write_ac_fault       = ac_fault_s;
  assign bus.busy                 = (state_q != ST_IDLE);
  assign bus.tlbwrite_do          = do_q;
  assign bus.tlbwrite_cpl         = cpl_q;
  assign bus.tlbwrite_address     = addr_q;
  assign bus.tlbwrite_length      = len_q;
  assign bus.tlbwrite_length_full = len_full_q;
  assign bus.tlbwrite_lock        = lock_q;
  assign bus.tlbwrite_rmw         = rmw_q;
  assign bus.tlbwrite_data        = data_q;

endmodule

// File: tb/tb_memory_write_split.sv
// Directed bench for memory_write_split: a 4-byte and an 8-byte instance,
// with the bench playing both the execute unit and the TLB.
module tb_memory_write_split;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  memory_write_split_if #(.ADDR_W(32), .MAX_BYTES(4)) bus4 ();
  memory_write_split_if #(.ADDR_W(32), .MAX_BYTES(8)) bus8 ();

  memory_write_split #(.ADDR_W(32), .LINE_BYTES(16), .MAX_BYTES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  memory_write_split #(.ADDR_W(32), .LINE_BYTES(16), .MAX_BYTES(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic init_inputs();
    bus4.wr_reset = 1'b0; bus4.write_do = 1'b0; bus4.write_cpl = 2'd0;
    bus4.write_address = 32'd0; bus4.write_length = 3'd1; bus4.write_lock = 1'b0;
    bus4.write_rmw = 1'b0; bus4.write_data = 32'd0; bus4.tlbwrite_done = 1'b0;
    bus4.tlbwrite_page_fault = 1'b0; bus4.tlbwrite_ac_fault = 1'b0;
    bus8.wr_reset = 1'b0; bus8.write_do = 1'b0; bus8.write_cpl = 2'd0;
    bus8.write_address = 32'd0; bus8.write_length = 4'd1; bus8.write_lock = 1'b0;
    bus8.write_rmw = 1'b0; bus8.write_data = 64'd0; bus8.tlbwrite_done = 1'b0;
    bus8.tlbwrite_page_fault = 1'b0; bus8.tlbwrite_ac_fault = 1'b0;
  endtask

  task automatic drive4(input logic [31:0] addr, input logic [2:0] len, input logic [31:0] data);
    bus4.write_do = 1'b1; bus4.write_address = addr; bus4.write_length = len;
    bus4.write_data = data; bus4.write_cpl = 2'd0; bus4.write_lock = 1'b0; bus4.write_rmw = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus4.write_done, bus4.write_page_fault, bus4.write_ac_fault, bus4.busy, bus4.tlbwrite_do,
         bus4.tlbwrite_cpl, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_length_full,
         bus4.tlbwrite_lock, bus4.tlbwrite_rmw, bus4.tlbwrite_data} !== 81'd0) begin
      failures++;
      $display("FAIL reset4: got busy=%b do=%b addr=%h data=%h, all must be 0",
               bus4.busy, bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_data);
    end
    checks++;
    if ({bus8.write_done, bus8.write_page_fault, bus8.write_ac_fault, bus8.busy, bus8.tlbwrite_do,
         bus8.tlbwrite_address, bus8.tlbwrite_length, bus8.tlbwrite_data} !== 109'd0) begin
      failures++;
      $display("FAIL reset8: got busy=%b do=%b addr=%h data=%h, all must be 0",
               bus8.busy, bus8.tlbwrite_do, bus8.tlbwrite_address, bus8.tlbwrite_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive4(32'h1000_0004, 3'd4, 32'hDDCC_BBAA);
    bus4.write_cpl = 2'd3; bus4.write_lock = 1'b1; bus4.write_rmw = 1'b0;
    @(negedge clk);
    bus4.write_address = 32'h2000_0000;
    bus4.write_data    = 32'h1234_5678;
    #1;
    checks++;
    if ({bus4.tlbwrite_do, bus4.busy, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_length_full,
         bus4.tlbwrite_data, bus4.tlbwrite_cpl, bus4.tlbwrite_lock, bus4.tlbwrite_rmw}
        !== {1'b1, 1'b1, 32'h1000_0004, 3'd4, 3'd4, 32'hDDCC_BBAA, 2'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_req: got do=%b addr=%h len=%0d full=%0d data=%h cpl=%0d lock=%b, expected 1 10000004 4 4 ddccbbaa 3 1",
               bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_length_full,
               bus4.tlbwrite_data, bus4.tlbwrite_cpl, bus4.tlbwrite_lock);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus4.tlbwrite_address, bus4.write_done} !== {32'h1000_0004, 1'b0}) begin
      failures++;
      $display("FAIL busy_ignore: got addr=%h done=%b, expected 10000004 0", bus4.tlbwrite_address, bus4.write_done);
    end
    bus4.tlbwrite_done = 1'b1;
    #1;
    checks++;
    if (bus4.write_done !== 1'b1) begin
      failures++;
      $display("FAIL single_done: got write_done=%b expected 1", bus4.write_done);
    end
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
    bus4.write_do = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.tlbwrite_do, bus4.write_done} !== 3'b000) begin
      failures++;
      $display("FAIL single_idle: got busy/do/done=%b expected 000", {bus4.busy, bus4.tlbwrite_do, bus4.write_done});
    end
  endtask

  task automatic test_split(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp_addr2,
                            input logic [31:0] exp_data2);
    @(negedge clk);
    drive4(addr, 3'd4, data);
    @(negedge clk);
    bus4.write_do = 1'b0;
    #1;
    checks++;
    if ({bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_length_full, bus4.tlbwrite_data}
        !== {1'b1, addr, 3'd2, 3'd4, data}) begin
      failures++;
      $display("FAIL split_part1: got do=%b addr=%h len=%0d full=%0d data=%h, expected 1 %h 2 4 %h",
               bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_length_full,
               bus4.tlbwrite_data, addr, data);
    end
    bus4.tlbwrite_done = 1'b1;
    #1;
    checks++;
    if (bus4.write_done !== 1'b0) begin
      failures++;
      $display("FAIL split_early_done: got write_done=%b expected 0", bus4.write_done);
    end
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
    #1;
    checks++;
    if ({bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_length_full, bus4.tlbwrite_data}
        !== {1'b1, exp_addr2, 3'd2, 3'd4, exp_data2}) begin
      failures++;
      $display("FAIL split_part2: got do=%b addr=%h len=%0d full=%0d data=%h, expected 1 %h 2 4 %h",
               bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_length_full,
               bus4.tlbwrite_data, exp_addr2, exp_data2);
    end
    bus4.tlbwrite_done = 1'b1;
    #1;
    checks++;
    if (bus4.write_done !== 1'b1) begin
      failures++;
      $display("FAIL split_done: got write_done=%b expected 1", bus4.write_done);
    end
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.tlbwrite_do} !== 2'b00) begin
      failures++;
      $display("FAIL split_idle: got busy/do=%b expected 00", {bus4.busy, bus4.tlbwrite_do});
    end
  endtask

  task automatic test_split8();
    @(negedge clk);
    bus8.write_do = 1'b1; bus8.write_address = 32'h0000_0FFB; bus8.write_length = 4'd8;
    bus8.write_data = 64'h8877_6655_4433_2211;
    @(negedge clk);
    bus8.write_do = 1'b0;
    #1;
    checks++;
    if ({bus8.tlbwrite_do, bus8.tlbwrite_address, bus8.tlbwrite_length, bus8.tlbwrite_length_full, bus8.tlbwrite_data}
        !== {1'b1, 32'h0000_0FFB, 4'd5, 4'd8, 64'h8877_6655_4433_2211}) begin
      failures++;
      $display("FAIL split8_part1: got do=%b addr=%h len=%0d full=%0d data=%h, expected 1 00000ffb 5 8 8877665544332211",
               bus8.tlbwrite_do, bus8.tlbwrite_address, bus8.tlbwrite_length, bus8.tlbwrite_length_full, bus8.tlbwrite_data);
    end
    bus8.tlbwrite_done = 1'b1;
    @(negedge clk);
    bus8.tlbwrite_done = 1'b0;
    #1;
    checks++;
    if ({bus8.tlbwrite_do, bus8.tlbwrite_address, bus8.tlbwrite_length, bus8.tlbwrite_data}
        !== {1'b1, 32'h0000_1000, 4'd3, 64'h0000_0000_0088_7766}) begin
      failures++;
      $display("FAIL split8_part2: got do=%b addr=%h len=%0d data=%h, expected 1 00001000 3 0000000000887766",
               bus8.tlbwrite_do, bus8.tlbwrite_address, bus8.tlbwrite_length, bus8.tlbwrite_data);
    end
    bus8.tlbwrite_done = 1'b1;
    #1;
    checks++;
    if (bus8.write_done !== 1'b1) begin
      failures++;
      $display("FAIL split8_done: got write_done=%b expected 1", bus8.write_done);
    end
    @(negedge clk);
    bus8.tlbwrite_done = 1'b0;
  endtask

  task automatic test_fault_part2();
    test_split_to_second(32'h0000_002E, 32'hAABB_CCDD);
    bus4.tlbwrite_done = 1'b1;
    bus4.tlbwrite_page_fault = 1'b1;
    #1;
    checks++;
    if ({bus4.write_done, bus4.write_page_fault} !== 2'b01) begin
      failures++;
      $display("FAIL pf_priority: got done/pf=%b expected 01", {bus4.write_done, bus4.write_page_fault});
    end
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
    bus4.tlbwrite_page_fault = 1'b0;
    drive4(32'h0000_0040, 3'd1, 32'h0000_0099);
    #1;
    checks++;
    if ({bus4.busy, bus4.tlbwrite_do, bus4.write_page_fault, bus4.write_ac_fault} !== 4'b0010) begin
      failures++;
      $display("FAIL pf_sticky: got busy/do/pf/ac=%b expected 0010",
               {bus4.busy, bus4.tlbwrite_do, bus4.write_page_fault, bus4.write_ac_fault});
    end
    @(negedge clk);
    bus4.write_do = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.tlbwrite_do} !== 2'b00) begin
      failures++;
      $display("FAIL pf_blocks_accept: got busy/do=%b expected 00", {bus4.busy, bus4.tlbwrite_do});
    end
    bus4.wr_reset = 1'b1;
    @(negedge clk);
    bus4.wr_reset = 1'b0;
    #1;
    checks++;
    if (bus4.write_page_fault !== 1'b0) begin
      failures++;
      $display("FAIL pf_cleared: got write_page_fault=%b expected 0", bus4.write_page_fault);
    end
  endtask

  task automatic test_split_to_second(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    drive4(addr, 3'd4, data);
    @(negedge clk);
    bus4.write_do = 1'b0;
    bus4.tlbwrite_done = 1'b1;
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
  endtask

  task automatic test_ac_fault_first();
    @(negedge clk);
    drive4(32'h0000_006D, 3'd4, 32'h0102_0304);
    @(negedge clk);
    bus4.write_do = 1'b0;
    bus4.tlbwrite_ac_fault = 1'b1;
    #1;
    checks++;
    if ({bus4.write_done, bus4.write_ac_fault, bus4.tlbwrite_length} !== {1'b0, 1'b1, 3'd3}) begin
      failures++;
      $display("FAIL ac_part1: got done=%b ac=%b len=%0d expected 0 1 3",
               bus4.write_done, bus4.write_ac_fault, bus4.tlbwrite_length);
    end
    @(negedge clk);
    bus4.tlbwrite_ac_fault = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.tlbwrite_do, bus4.write_ac_fault, bus4.write_page_fault} !== 4'b0010) begin
      failures++;
      $display("FAIL ac_no_part2: got busy/do/ac/pf=%b expected 0010",
               {bus4.busy, bus4.tlbwrite_do, bus4.write_ac_fault, bus4.write_page_fault});
    end
    bus4.wr_reset = 1'b1;
    @(negedge clk);
    bus4.wr_reset = 1'b0;
    #1;
    checks++;
    if (bus4.write_ac_fault !== 1'b0) begin
      failures++;
      $display("FAIL ac_cleared: got write_ac_fault=%b expected 0", bus4.write_ac_fault);
    end
  endtask

  task automatic test_reset_waiting();
    @(negedge clk);
    drive4(32'h0000_003E, 3'd4, 32'h1122_3344);
    @(negedge clk);
    bus4.write_do = 1'b0;
    bus4.wr_reset = 1'b1;
    @(negedge clk);
    bus4.wr_reset = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.tlbwrite_do, bus4.tlbwrite_address} !== {1'b1, 1'b1, 32'h0000_003E}) begin
      failures++;
      $display("FAIL rw_hold: got busy=%b do=%b addr=%h expected 1 1 0000003e",
               bus4.busy, bus4.tlbwrite_do, bus4.tlbwrite_address);
    end
    bus4.tlbwrite_done = 1'b1;
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
    #1;
    checks++;
    if ({bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_data}
        !== {1'b1, 32'h0000_0040, 3'd2, 32'h0000_1122}) begin
      failures++;
      $display("FAIL rw_part2: got do=%b addr=%h len=%0d data=%h expected 1 00000040 2 00001122",
               bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_data);
    end
    bus4.tlbwrite_done = 1'b1;
    #1;
    checks++;
    if (bus4.write_done !== 1'b0) begin
      failures++;
      $display("FAIL rw_done_suppressed: got write_done=%b expected 0", bus4.write_done);
    end
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
    drive4(32'h0000_0050, 3'd1, 32'h0000_005A);
    @(negedge clk);
    bus4.write_do = 1'b0;
    #1;
    checks++;
    if ({bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_data}
        !== {1'b1, 32'h0000_0050, 3'd1, 32'h0000_005A}) begin
      failures++;
      $display("FAIL rw_next_accept: got do=%b addr=%h len=%0d data=%h expected 1 00000050 1 0000005a",
               bus4.tlbwrite_do, bus4.tlbwrite_address, bus4.tlbwrite_length, bus4.tlbwrite_data);
    end
    bus4.tlbwrite_done = 1'b1;
    #1;
    checks++;
    if (bus4.write_done !== 1'b1) begin
      failures++;
      $display("FAIL rw_next_done: got write_done=%b expected 1", bus4.write_done);
    end
    @(negedge clk);
    bus4.tlbwrite_done = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_split(32'h1000_000E, 32'h4433_2211, 32'h1000_0010, 32'h0000_4433);
    test_split8();
    test_split(32'hFFFF_FFFE, 32'h8765_4321, 32'h0000_0000, 32'h0000_8765);
    test_fault_part2();
    test_ac_fault_first();
    test_reset_waiting();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
